// File: rtl/latch_bank.sv
// latch_bank: per-channel capture-and-hold word bank with valid/ack handshake and overrun counter
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   i_data     CHANNELS*WIDTH channel words, channel c at [c*WIDTH +: WIDTH]
//   i_load     per-channel capture strobe
//   i_freeze   global hold, masks all loads (acks still accepted)
//   i_ack      per-channel consume strobe
//   i_ovr_clr  clears the overrun counter, wins over same-cycle overruns
//   o_d_out    held words, same packing as i_data
//   o_valid    per-channel unacknowledged-word flag
//   o_any_valid registered OR of next-state valid
//   o_ovr_cnt  saturating overrun count
module latch_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter bit STICKY   = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_load,
  input  logic                      i_freeze,
  input  logic [CHANNELS-1:0]       i_ack,
  input  logic                      i_ovr_clr,
  output logic [CHANNELS*WIDTH-1:0] o_d_out,
  output logic [CHANNELS-1:0]       o_valid,
  output logic                      o_any_valid,
  output logic [CNT_W-1:0]          o_ovr_cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  localparam logic [CNT_W+5:0] MAX = {6'b0, {CNT_W{1'b1}}};
  logic [CHANNELS-1:0] w_eff_load;
  logic [CHANNELS-1:0] w_ovr;
  logic [CHANNELS-1:0] w_valid_nxt;
  logic [5:0]          w_inc;
  logic [CNT_W+5:0]    w_sum;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_any;
  assign w_eff_load = i_load & ~{CHANNELS{i_freeze}};
  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_word;
      logic [WIDTH-1:0] w_word_nxt;
      logic             w_ovr_c;
      always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_ovr_c     = 1'b0;
        case (r_state)
          EMPTY: if (w_eff_load[c]) begin
            w_state_nxt = FULL;
            w_word_nxt  = i_data[c*WIDTH +: WIDTH];
          end
          FULL: begin
            if (i_ack[c] && !w_eff_load[c]) w_state_nxt = EMPTY;
            else if (i_ack[c] && w_eff_load[c]) w_word_nxt = i_data[c*WIDTH +: WIDTH];
            else if (w_eff_load[c]) begin
              w_ovr_c    = 1'b1;
              w_word_nxt = STICKY ? r_word : i_data[c*WIDTH +: WIDTH];
            end
          end
          default: w_state_nxt = EMPTY;
        endcase
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state <= EMPTY;
          r_word  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_word  <= w_word_nxt;
        end
      end
      assign w_ovr[c]                   = w_ovr_c;
      assign w_valid_nxt[c]             = (w_state_nxt == FULL);
      assign o_valid[c]                 = (r_state == FULL);
      assign o_d_out[c*WIDTH +: WIDTH]  = r_word;
    end
  endgenerate
  always_comb begin
    w_inc = '0;
    for (int i = 0; i < CHANNELS; i++) w_inc = w_inc + 6'(w_ovr[i]);
  end
  // wide intermediate keeps the saturating add from wrapping
  assign w_sum = {6'b0, r_cnt} + {{CNT_W{1'b0}}, w_inc};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_any <= 1'b0;
    end else begin
      r_cnt <= i_ovr_clr ? '0 : (w_sum > MAX ? MAX[CNT_W-1:0] : w_sum[CNT_W-1:0]);
      r_any <= |w_valid_nxt;
    end
  end
  assign o_ovr_cnt   = r_cnt;
  assign o_any_valid = r_any;
endmodule

// File: doc/latch_bank.md
Name: latch_bank

Overview:
- Parametrised, clocked successor to the single-bit load latch.
- Captures CHANNELS independent WIDTH-bit words, each on its own load strobe, and holds each word until a consumer acknowledges it.
- Per-channel valid/ack handshake; mode-selectable overwrite or sticky policy on collision; saturating overrun counter for status.
- Sits between producer strobes and a register-read or status path.

Parameters:
- WIDTH, 8, bits per channel word.
- CHANNELS, 4, number of independent channels (1..32).
- STICKY, 0, 0 = a new load overwrites an unacknowledged word; 1 = the held word is kept and the new load is dropped.
- CNT_W, 8, width of the overrun counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- data  in  CHANNELS*WIDTH  channel words; channel c occupies bits [c*WIDTH +: WIDTH].
- load  in  CHANNELS  per-channel capture strobe.
- freeze  in  1  global hold; while high all loads are ignored.
- ack  in  CHANNELS  per-channel consume strobe.
- d_out  out  CHANNELS*WIDTH  held words, same packing as data.
- valid  out  CHANNELS  channel c holds an unacknowledged word.
- any_valid  out  1  OR of valid, registered.
- ovr_cnt  out  CNT_W  saturating overrun count.
- ovr_clr  in  1  clears ovr_cnt.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset: when rst_n=0 at a rising edge, d_out=0, valid=0, any_valid=0, ovr_cnt=0. The reset takes effect even mid-operation; a load in the reset cycle is lost.
- Per-channel FSM:
  - EMPTY (valid=0) / FULL (valid=1).
  - eff_load[c] = load[c] & ~freeze.
- EMPTY transitions:
  - eff_load: capture data[c], go FULL.
  - ack while EMPTY is ignored.
- FULL transitions:
  - ack & ~eff_load: go EMPTY; d_out holds its last value.
  - ack & eff_load: capture the new word, stay FULL; not an overrun.
  - ~ack & eff_load, STICKY=0: overwrite d_out, stay FULL; counts as an overrun.
  - ~ack & eff_load, STICKY=1: keep d_out, drop the new word; counts as an overrun.
  - Otherwise: hold.
- Latency:
  - A capture at edge N is visible on d_out/valid immediately after edge N (one register stage). There is no combinational path from data to d_out.
  - any_valid reflects the valid value from after the same edge, i.e. it is computed from next-state valid and registered alongside it.
- freeze:
  - Ack still works while freeze is high.
  - Loads dropped by freeze are not counted as overruns.
- Overrun counter:
  - ovr_inc = popcount of the channels that overrun this cycle (0..CHANNELS).
  - ovr_cnt_next = min(ovr_cnt + ovr_inc, 2^CNT_W-1). Use a CNT_W+6 bit intermediate so the saturating add cannot wrap.
  - ovr_clr has priority: ovr_cnt becomes 0 and that cycle's overruns are discarded.
- Channels are fully independent. Simultaneous events on different channels never interact except through ovr_cnt.

Test Plan:
- Reset/capture: rst_n=0 for 2 cycles, then WIDTH=8, CHANNELS=4, load=4'b0001, data[7:0]=8'hA5 -> after 1 edge d_out[7:0]=A5, valid=0001, any_valid=1, others 0, ovr_cnt=0.
- Ack/hold: ack[0] one cycle -> valid=0000, any_valid=0, d_out[7:0] still A5; a repeated ack on the empty channel changes nothing.
- Overwrite vs sticky: ch1 FULL with 8'h11, load 8'h22 without ack:
  - STICKY=0 -> d_out[15:8]=22, ovr_cnt=1.
  - STICKY=1 -> d_out[15:8]=11, ovr_cnt=1.
- Simultaneous load+ack: ch2 FULL with 8'h33, load 8'h44 with ack[2] in the same cycle -> d_out[23:16]=44, valid[2]=1, ovr_cnt unchanged.
- Freeze and multi-overrun: all 4 channels FULL, load=1111 with freeze=1 -> nothing changes, ovr_cnt unchanged. Then freeze=0, load=1111 -> ovr_cnt increases by 4. With CNT_W=3 starting at 6, the same stimulus -> ovr_cnt=7 (saturates).
- Clear priority and reset mid-operation: ovr_clr=1 in the same cycle as 2 overruns -> ovr_cnt=0. rst_n=0 while channels are FULL and load is active -> all outputs 0 after the edge.
